laser_sweep_sched: RTL and testbench

Sequencer for the two-circle laser coverage search. It sweeps all 256 candidate centres of the 16x16 grid through an external point-counting datapath over a request/acknowledge handshake. It alternates which circle moves on each sweep and keeps the best positions. It stops when the placement converges or when an iteration cap is reached. It sits between the point-loading front end and the coverage datapath, and it owns the C1/C2 result registers.

---
 rtl/laser_pkg.sv | 17 +
 rtl/laser_cand_gen.sv | 27 ++
 rtl/laser_sweep_sched.sv | 179 +++++++++++++++++
 tb/tb_laser_sweep_sched.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/laser_pkg.sv
// Shared types and constants for the two-circle laser coverage sequencer.
package laser_pkg;
  localparam int COORD_W  = 4;
  localparam int CNT_W    = 6;
  localparam int GRID_MAX = (1 << COORD_W) - 1;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ISSUE,
    S_UPDATE,
    S_SWEEP_END,
    S_FINISH
  } sched_state_t;
endpackage

// File: rtl/laser_cand_gen.sv
// Raster candidate-centre counter: X runs fastest, last flags the final grid corner.
module laser_cand_gen #(
  parameter int COORD_W = laser_pkg::COORD_W
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               clear,
  input  logic               step,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      x <= x + 1'b1;
      if (x == '1) y <= y + 1'b1;
    end
  end

  assign last = (x == '1) && (y == '1);
endmodule

// File: rtl/laser_sweep_sched.sv
// Alternating-circle sweep sequencer over the coverage datapath handshake.
// Optional acknowledge watchdog and ERR port: define LASER_SCHED_TIMEOUT_EN.
module laser_sweep_sched import laser_pkg::*; #(
  parameter int COORD_W  = laser_pkg::COORD_W,
  parameter int CNT_W    = laser_pkg::CNT_W,
  parameter int MAX_ITER = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  output logic               BUSY,
  output logic [COORD_W-1:0] CAND_X,
  output logic [COORD_W-1:0] CAND_Y,
  output logic [COORD_W-1:0] OTHER_X,
  output logic [COORD_W-1:0] OTHER_Y,
  output logic               CNT_REQ,
  input  logic               CNT_ACK,
  input  logic [CNT_W-1:0]   CNT_UNION,
  input  logic [CNT_W-1:0]   CNT_SOLO,
  output logic [COORD_W-1:0] C1X,
  output logic [COORD_W-1:0] C1Y,
  output logic [COORD_W-1:0] C2X,
  output logic [COORD_W-1:0] C2Y,
  output logic [4:0]         ITER,
  output logic               DONE
`ifdef LASER_SCHED_TIMEOUT_EN
  ,
  output logic               ERR
`endif
);
  sched_state_t state_q, state_d;

  logic [COORD_W-1:0] cx, cy;
  logic               last, cand_clear, cand_step;
  logic [CNT_W-1:0]   best_q, solo1_q, solo2_q, un_q, so_q, solo_mv;
  logic [1:0]         quiet_q, quiet_nxt;
  logic [4:0]         iter_nxt;
  logic               changed_q, turn_q, take, sweep_stop;

  laser_cand_gen #(.COORD_W(COORD_W)) u_cand (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clear (cand_clear),
    .step  (cand_step),
    .x     (cx),
    .y     (cy),
    .last  (last)
  );

  assign cand_clear = (state_q == S_INIT) || (state_q == S_SWEEP_END);
  assign cand_step  = (state_q == S_UPDATE) && !last;

  // turn_q = 0: C1 moves against a stationary C2; turn_q = 1: the reverse.
  assign solo_mv    = turn_q ? solo2_q : solo1_q;
  assign take       = (un_q > best_q) || ((un_q == best_q) && (so_q > solo_mv));
  assign quiet_nxt  = changed_q ? 2'd0 : quiet_q + 2'd1;
  assign iter_nxt   = ITER + 5'd1;
  assign sweep_stop = (quiet_nxt == 2'd2) || (iter_nxt == 5'(MAX_ITER));

`ifdef LASER_SCHED_TIMEOUT_EN
  // Trip on the 63rd consecutive ISSUE cycle without an acknowledge.
  localparam logic [5:0] WDOG_LIMIT = 6'd62;
  logic [5:0] wdog_q;
  logic       err_q, timeout;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
`ifdef LASER_SCHED_TIMEOUT_EN
    timeout = 1'b0;
`endif
    case (state_q)
      S_IDLE:      if (START) state_d = S_INIT;
      S_INIT:      state_d = S_ISSUE;
      S_ISSUE: begin
        if (CNT_ACK) state_d = S_UPDATE;
`ifdef LASER_SCHED_TIMEOUT_EN
        else if (wdog_q == WDOG_LIMIT) begin
          state_d = S_FINISH;
          timeout = 1'b1;
        end
`endif
      end
      S_UPDATE:    state_d = last ? S_SWEEP_END : S_ISSUE;
      S_SWEEP_END: state_d = sweep_stop ? S_FINISH : S_ISSUE;
      S_FINISH:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      C1X       <= '0;
      C1Y       <= '0;
      C2X       <= '0;
      C2Y       <= '0;
      ITER      <= '0;
      best_q    <= '0;
      solo1_q   <= '0;
      solo2_q   <= '0;
      un_q      <= '0;
      so_q      <= '0;
      quiet_q   <= '0;
      changed_q <= 1'b0;
      turn_q    <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          C1X       <= '0;
          C1Y       <= '0;
          C2X       <= '0;
          C2Y       <= '0;
          ITER      <= '0;
          best_q    <= '0;
          solo1_q   <= '0;
          solo2_q   <= '0;
          quiet_q   <= '0;
          changed_q <= 1'b0;
          turn_q    <= 1'b0;
        end
        S_ISSUE: begin
          if (CNT_ACK) begin
            un_q <= CNT_UNION;
            so_q <= CNT_SOLO;
          end
        end
        S_UPDATE: begin
          if (take) begin
            if (turn_q) begin
              C2X     <= cx;
              C2Y     <= cy;
              solo2_q <= so_q;
            end else begin
              C1X     <= cx;
              C1Y     <= cy;
              solo1_q <= so_q;
            end
            best_q    <= un_q;
            changed_q <= 1'b1;
          end
        end
        S_SWEEP_END: begin
          ITER      <= iter_nxt;
          quiet_q   <= quiet_nxt;
          changed_q <= 1'b0;
          turn_q    <= ~turn_q;
        end
        default: ;
      endcase
    end
  end

`ifdef LASER_SCHED_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= ((state_q == S_ISSUE) && !CNT_ACK) ? wdog_q + 6'd1 : 6'd0;
      err_q  <= timeout;
    end
  end

  assign ERR = err_q;
`endif

  assign BUSY    = (state_q != S_IDLE);
  assign CNT_REQ = (state_q == S_ISSUE);
  assign DONE    = (state_q == S_FINISH);
  assign CAND_X  = cx;
  assign CAND_Y  = cy;
  assign OTHER_X = turn_q ? C1X : C2X;
  assign OTHER_Y = turn_q ? C1Y : C2Y;
endmodule

// File: tb/tb_laser_sweep_sched.sv
// Directed bench: Euclidean r=4 coverage model over two 20-point clusters.
module tb_laser_sweep_sched;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start_c = 1'b0;
  always #5 clk = ~clk;

  logic       busy, req, done, busy_c, req_c, done_c;
  logic       ack = 1'b0, ack_c = 1'b0;
  logic [3:0] cand_x, cand_y, oth_x, oth_y, c1x, c1y, c2x, c2y;
  logic [3:0] cand_xc, cand_yc, oth_xc, oth_yc, c1xc, c1yc, c2xc, c2yc;
  logic [5:0] un = '0, so = '0, un_c = '0, so_c = '0;
  logic [4:0] iter, iter_c;
`ifdef LASER_SCHED_TIMEOUT_EN
  logic err, err_c;
`endif

  int n_chk = 0, n_fail = 0, cyc = 0, t0 = 0;
  int stall = 0, waited = 0, viol = 0;
  bit ack_en = 1'b1, pend = 1'b0;
  logic [15:0] held = '0;

  laser_sweep_sched #(.MAX_ITER(16)) u_dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .BUSY(busy),
    .CAND_X(cand_x), .CAND_Y(cand_y), .OTHER_X(oth_x), .OTHER_Y(oth_y),
    .CNT_REQ(req), .CNT_ACK(ack), .CNT_UNION(un), .CNT_SOLO(so),
    .C1X(c1x), .C1Y(c1y), .C2X(c2x), .C2Y(c2y), .ITER(iter), .DONE(done)
`ifdef LASER_SCHED_TIMEOUT_EN
    , .ERR(err)
`endif
  );

  laser_sweep_sched #(.MAX_ITER(2)) u_cap (
    .CLK(clk), .RST_N(rst_n), .START(start_c), .BUSY(busy_c),
    .CAND_X(cand_xc), .CAND_Y(cand_yc), .OTHER_X(oth_xc), .OTHER_Y(oth_yc),
    .CNT_REQ(req_c), .CNT_ACK(ack_c), .CNT_UNION(un_c), .CNT_SOLO(so_c),
    .C1X(c1xc), .C1Y(c1yc), .C2X(c2xc), .C2Y(c2yc), .ITER(iter_c), .DONE(done_c)
`ifdef LASER_SCHED_TIMEOUT_EN
    , .ERR(err_c)
`endif
  );

  always @(posedge clk) cyc++;

  function automatic int d2(input int ax, input int ay, input int bx, input int by);
    return (ax - bx) * (ax - bx) + (ay - by) * (ay - by);
  endfunction

  // 20 points at (3,3) and 20 at (12,12); a point is covered within radius 4.
  function automatic void model(input int cx, input int cy, input int ox, input int oy,
                                output logic [5:0] u, output logic [5:0] s);
    int uu, ss, q;
    bit ic, io;
    uu = 0;
    ss = 0;
    for (int p = 0; p < 2; p++) begin
      q  = (p == 0) ? 3 : 12;
      ic = d2(cx, cy, q, q) <= 16;
      io = d2(ox, oy, q, q) <= 16;
      if (ic) ss += 20;
      if (ic || io) uu += 20;
    end
    u = 6'(uu);
    s = 6'(ss);
  endfunction

  // Main datapath model: optional ACK delay, plus a hold-stability monitor.
  always @(negedge clk) begin
    if (pend && rst_n && (!req || {cand_x, cand_y, oth_x, oth_y} != held)) viol++;
    if (req && ack_en && waited >= stall) begin
      ack    = 1'b1;
      waited = 0;
    end else begin
      ack    = 1'b0;
      waited = req ? waited + 1 : 0;
    end
    pend = req && !ack;
    held = {cand_x, cand_y, oth_x, oth_y};
    model(int'(cand_x), int'(cand_y), int'(oth_x), int'(oth_y), un, so);
  end

  always @(negedge clk) begin
    ack_c = req_c;
    model(int'(cand_xc), int'(cand_yc), int'(oth_xc), int'(oth_yc), un_c, so_c);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_req"}, 32'(req), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_cand_other"}, {cand_x, cand_y, oth_x, oth_y}, 0);
    chk({tag, "_cregs"}, {c1x, c1y, c2x, c2y}, 0);
    chk({tag, "_iter"}, 32'(iter), 0);
`ifdef LASER_SCHED_TIMEOUT_EN
    chk({tag, "_err"}, 32'(err), 0);
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk(tag, 32'(seen), 1);
  endtask

  task automatic wait_iter(input string tag, input int n, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = (iter == 5'(n));
    end
    chk(tag, 32'(seen), 1);
  endtask

  task automatic wait_cand(input string tag, input int x, input int y, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = req && (cand_x == 4'(x)) && (cand_y == 4'(y)) && (iter == 5'd0);
    end
    chk(tag, 32'(seen), 1);
  endtask

  initial begin
    // Reset held: START must be ignored, everything at zero.
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    chk_idle("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Convergence with same-cycle acknowledge.
    pulse_start();
    chk("start_busy", 32'(busy), 1);
    chk("start_noreq", 32'(req), 0);
    @(negedge clk);
    chk("first_req", {req, cand_x, cand_y}, 9'h100);
    wait_iter("conv_it1", 1, 700);
    chk("conv_c1_s1", {c1x, c1y}, 8'h10);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_iter("conv_it2", 2, 700);
    chk("conv_c2_s2", {c1x, c1y, c2x, c2y}, 16'h10c8);
    wait_done("conv_done", 1500);
    chk("conv_iter", 32'(iter), 4);
    chk("conv_c", {c1x, c1y, c2x, c2y}, 16'h10c8);
    chk("conv_cycles", cyc - t0, 2053);
    @(negedge clk);
    chk("conv_after", {busy, done}, 0);

    // Five-cycle acknowledge stall on every request.
    stall = 5;
    viol  = 0;
    pulse_start();
    wait_done("stall_done", 8000);
    chk("stall_iter", 32'(iter), 4);
    chk("stall_c", {c1x, c1y, c2x, c2y}, 16'h10c8);
    chk("stall_cycles", cyc - t0, 7173);
    chk("stall_stable", viol, 0);
    stall = 0;
    @(negedge clk);

    // Reset in the middle of sweep 1, then a clean rerun.
    pulse_start();
    wait_cand("mid_reach", 7, 4, 700);
    rst_n = 1'b0;
    #1;
    chk_idle("mid");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    wait_done("mid_done", 3000);
    chk("mid_c", {c1x, c1y, c2x, c2y}, 16'h10c8);
    chk("mid_iter", 32'(iter), 4);
    chk("mid_cycles", cyc - t0, 2053);

    // Iteration cap of 2 on the second instance.
    begin
      bit seen = 1'b0;
      int tc;
      @(negedge clk) start_c = 1'b1;
      @(negedge clk) start_c = 1'b0;
      tc = cyc;
      for (int i = 0; i < 1500 && !seen; i++) begin
        @(negedge clk);
        seen = done_c;
      end
      chk("cap_done", 32'(seen), 1);
      chk("cap_c", {c1xc, c1yc, c2xc, c2yc}, 16'h10c8);
      chk("cap_iter", 32'(iter_c), 2);
      chk("cap_cycles", cyc - tc, 1027);
    end

`ifdef LASER_SCHED_TIMEOUT_EN
    // Acknowledge never arrives: watchdog ends the search.
    ack_en = 1'b0;
    pulse_start();
    wait_done("to_done", 200);
    chk("to_err", 32'(err), 1);
    chk("to_cycles", cyc - t0, 64);
    @(negedge clk);
    chk("to_after", {busy, done, err}, 0);
    ack_en = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
